// File: rtl/cnn_maxpool_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a row-major IMG_W x IMG_H feature map.
// A half-width line buffer carries even-row pair maxima to the matching odd-row pair.
module cnn_maxpool_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMG_W      = 8,
    parameter int unsigned IMG_H      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned HALF_W = IMG_W / 2;
    localparam int unsigned IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic signed [DATA_WIDTH-1:0] in_px;
    logic signed [DATA_WIDTH-1:0] hold_q;
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [DATA_WIDTH-1:0] lb_rd;
    logic signed [DATA_WIDTH-1:0] win_max;
    logic signed [DATA_WIDTH-1:0] linebuf_q [HALF_W];
    logic [IDX_W-1:0]             lb_idx;

    logic                  accept;
    logic                  col_odd;
    logic                  row_odd;
    logic                  col_last;
    logic                  row_last;
    logic                  lb_write;
    logic                  load_out;
    logic                  out_fire;

    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;

    // A stalled output blocks new input so the result register is never overwritten.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    assign col_odd  = col_q[0];
    assign row_odd  = row_q[0];
    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));

    assign in_px    = $signed(in_data);
    assign lb_idx   = IDX_W'(col_q >> 1);
    assign lb_rd    = linebuf_q[lb_idx];
    assign lb_write = accept && col_odd && !row_odd;
    assign load_out = accept && col_odd && row_odd;

    always_comb begin
        pair_max = (in_px > hold_q) ? in_px : hold_q;
        win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (accept && !col_odd) begin
            hold_q <= in_px;
        end
    end

    // Every entry is written on an even row before being read on the next odd row.
    always_ff @(posedge clk) begin
        if (lb_write) begin
            linebuf_q[lb_idx] <= pair_max;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (load_out) begin
            out_data_q  <= win_max;
            out_valid_q <= 1'b1;
            out_last_q  <= row_last && col_last;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    stall_stable_a : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

    no_accept_on_stall_a : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |-> !in_ready);

endmodule

// File: tb/tb_cnn_maxpool_stream.sv
// Bench for cnn_maxpool_stream on a 4x4 map: directed and random frames checked
// against a window-max model computed from whole frames.
module tb_cnn_maxpool_stream;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [1:0]  ready_mode;   // 0: low, 1: high, 2: random
    logic        rnd_bit = 1'b1;

    int          checks;
    int          errors;

    logic [31:0] exp_data [$];
    logic        exp_last [$];
    logic [31:0] frm [16];

    cnn_maxpool_stream #(
        .DATA_WIDTH (32),
        .IMG_W      (4),
        .IMG_H      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) #1 rnd_bit = 1'($urandom);
    assign out_ready = (ready_mode == 2'd2) ? rnd_bit : ready_mode[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Expected pooled outputs of one 4x4 frame, straight from the window definition.
    function automatic void model_frame(input logic [31:0] px [16]);
        for (int r = 0; r < 4; r += 2) begin
            for (int c = 0; c < 4; c += 2) begin
                int m;
                int v;
                m = px[r*4 + c];
                v = px[r*4 + c + 1];       if (v > m) m = v;
                v = px[(r+1)*4 + c];       if (v > m) m = v;
                v = px[(r+1)*4 + c + 1];   if (v > m) m = v;
                exp_data.push_back(32'(m));
                exp_last.push_back(r == 2 && c == 2);
            end
        end
    endfunction

    task automatic send(input logic [31:0] v, input bit bubbles);
        bit accepted;
        int g;
        if (bubbles) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_data  = v;
        in_valid = 1'b1;
        accepted = 1'b0;
        g        = 0;
        while (!accepted && g < 500) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            @(posedge clk); #1;
            g++;
        end
        if (!accepted) chk("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic send_frame(input bit bubbles);
        for (int i = 0; i < 16; i++) send(frm[i], bubbles);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_data.size() != 0 && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain_left", 32'(exp_data.size()), 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        ready_mode = 2'd1;

        fork
            begin : monitor
                logic        stalled;
                logic [31:0] held_data;
                logic        held_last;
                stalled = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        stalled = 1'b0;
                    end else begin
                        chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
                        if (stalled) begin
                            chk("stall_valid", 32'(out_valid), 32'd1);
                            chk("stall_data", out_data, held_data);
                            chk("stall_last", 32'(out_last), 32'(held_last));
                        end
                        if (out_valid && out_ready) begin
                            checks++;
                            assert (exp_data.size() > 0) else begin
                                errors++;
                                $error("FAIL out_unexpected got %0h exp none", out_data);
                            end
                            if (exp_data.size() > 0) begin
                                chk("out_data", out_data, exp_data.pop_front());
                                chk("out_last", 32'(out_last), 32'(exp_last.pop_front()));
                            end
                        end
                        stalled   = out_valid && !out_ready;
                        held_data = out_data;
                        held_last = out_last;
                    end
                end
            end
        join_none

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Ramp 0..15, continuous, with per-pixel latency and drain/load spacing
        for (int i = 0; i < 16; i++) frm[i] = 32'(i);
        model_frame(frm);
        for (int i = 0; i < 16; i++) begin
            send(frm[i], 1'b0);
            chk($sformatf("lat_px%0d", i), 32'(out_valid),
                32'(i == 5 || i == 7 || i == 13 || i == 15));
        end
        in_valid = 1'b0;
        drain();

        // Signed comparisons
        for (int i = 0; i < 16; i++) frm[i] = 32'(-100);
        frm[0] = 32'(-8); frm[1] = 32'(-3); frm[4] = 32'(-5); frm[5] = 32'(-1);
        model_frame(frm);
        send_frame(1'b0);
        drain();
        for (int i = 0; i < 16; i++) frm[i] = 32'(-100);
        frm[0] = 32'h7FFF_FFFF; frm[1] = 32'hFFFF_FFFF; frm[4] = 32'h8000_0000; frm[5] = 32'h0;
        model_frame(frm);
        send_frame(1'b0);
        drain();

        // Backpressure on the first output
        ready_mode = 2'd0;
        for (int i = 0; i < 16; i++) frm[i] = 32'(i);
        model_frame(frm);
        for (int i = 0; i < 6; i++) send(frm[i], 1'b0);
        in_valid = 1'b0;
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_data", out_data, 32'd5);
            @(posedge clk); #1;
        end
        ready_mode = 2'd1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        for (int i = 6; i < 16; i++) send(frm[i], 1'b0);
        in_valid = 1'b0;
        drain();

        // Bubbles over two back-to-back frames
        for (int i = 0; i < 16; i++) frm[i] = 32'(i);
        model_frame(frm);
        send_frame(1'b1);
        for (int i = 0; i < 16; i++) frm[i] = 32'(100 + i);
        model_frame(frm);
        send_frame(1'b1);
        drain();

        // Reset mid-frame with a pending output
        ready_mode = 2'd0;
        for (int i = 0; i < 6; i++) send(32'(i), 1'b0);
        in_valid = 1'b0;
        chk("abort_pending", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_dropped", 32'(out_valid), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 2'd1;
        for (int i = 0; i < 16; i++) frm[i] = 32'(20 + i);
        model_frame(frm);
        send_frame(1'b0);
        drain();

        // Random data, random bubbles, random backpressure
        ready_mode = 2'd2;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) frm[i] = $urandom;
            model_frame(frm);
            send_frame(1'b1);
        end
        ready_mode = 2'd1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
